// File: rtl/kim_alu_pkg.sv
// Shared ALU/decode definitions: ALU control codes, MIPS opcode/funct values
// and the decoded-control payloads used by the ID/EX boundary and the ALU.
package kim_alu_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  // Source of ALU operand B
  typedef enum logic [1:0] {
    B_SEL_RT   = 2'd0,
    B_SEL_SEXT = 2'd1,
    B_SEL_ZEXT = 2'd2
  } b_sel_e;

  typedef struct packed {
    alu_ctrl_e alu_control;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      illegal;
    b_sel_e    b_sel;
    logic      store_rt;
  } dec_t;

  typedef struct packed {
    logic      valid;
    alu_ctrl_e alu_control;
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    logic      branch;
    logic      illegal;
  } ex_ctrl_t;

endpackage

// File: rtl/kim_alu_dec_p.sv
// Combinational opcode/funct decoder: ALU operation, control flags,
// operand-B source select and illegal-instruction detection.
module kim_alu_dec_p
  import kim_alu_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output dec_t               dec_c
);

  always_comb begin
    dec_c             = '0;
    dec_c.alu_control = ALU_ADD;
    dec_c.b_sel       = B_SEL_RT;
    unique case (op)
      OP_RTYPE: begin
        dec_c.reg_write = 1'b1;
        unique case (funct)
          FN_ADD:  dec_c.alu_control = ALU_ADD;
          FN_SUB:  dec_c.alu_control = ALU_SUB;
          FN_AND:  dec_c.alu_control = ALU_AND;
          FN_OR:   dec_c.alu_control = ALU_OR;
          FN_NOR:  dec_c.alu_control = ALU_NOR;
          FN_SLT:  dec_c.alu_control = ALU_SLT;
          default: begin
            dec_c.reg_write = 1'b0;
            dec_c.illegal   = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec_c.b_sel     = B_SEL_SEXT;
        dec_c.mem_read  = 1'b1;
        dec_c.reg_write = 1'b1;
      end
      OP_SW: begin
        dec_c.b_sel     = B_SEL_SEXT;
        dec_c.mem_write = 1'b1;
        dec_c.store_rt  = 1'b1;
      end
      OP_BEQ: begin
        dec_c.alu_control = ALU_SUB;
        dec_c.branch      = 1'b1;
      end
      OP_ADDI: begin
        dec_c.b_sel     = B_SEL_SEXT;
        dec_c.reg_write = 1'b1;
      end
      OP_SLTI: begin
        dec_c.alu_control = ALU_SLT;
        dec_c.b_sel       = B_SEL_SEXT;
        dec_c.reg_write   = 1'b1;
      end
      OP_ANDI: begin
        dec_c.alu_control = ALU_AND;
        dec_c.b_sel       = B_SEL_ZEXT;
        dec_c.reg_write   = 1'b1;
      end
      OP_ORI: begin
        dec_c.alu_control = ALU_OR;
        dec_c.b_sel       = B_SEL_ZEXT;
        dec_c.reg_write   = 1'b1;
      end
      default: dec_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/kim_alu_dec_idex_p.sv
// ID/EX pipeline boundary: decodes the ID instruction, builds ALU operands and
// captures them in the EX register with stall/flush/bubble handling.
module kim_alu_dec_idex_p
  import kim_alu_pkg::*;
#(
  parameter int unsigned ALU_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [OP_W-1:0]           id_op,
  input  logic [FUNCT_W-1:0]        id_funct,
  input  logic [ALU_DATA_WIDTH-1:0] id_rs_data,
  input  logic [ALU_DATA_WIDTH-1:0] id_rt_data,
  input  logic [IMM_W-1:0]          id_imm,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      ex_valid,
  output logic [ALU_CTRL_W-1:0]     ex_alu_control,
  output logic [ALU_DATA_WIDTH-1:0] ex_a,
  output logic [ALU_DATA_WIDTH-1:0] ex_b,
  output logic [ALU_DATA_WIDTH-1:0] ex_store_data,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic                      ex_illegal
);

  localparam int unsigned DW = ALU_DATA_WIDTH;

  dec_t          dec_c;
  logic [DW-1:0] imm_sext_c;
  logic [DW-1:0] imm_zext_c;
  logic [DW-1:0] b_c;

  ex_ctrl_t      ctrl_q, ctrl_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] sd_q, sd_d;

  kim_alu_dec_p u_dec (
    .op    (id_op),
    .funct (id_funct),
    .dec_c (dec_c)
  );

  assign imm_sext_c = DW'($signed(id_imm));
  assign imm_zext_c = DW'(id_imm);

  // Operand B source
  always_comb begin
    b_c = id_rt_data;
    unique case (dec_c.b_sel)
      B_SEL_SEXT: b_c = imm_sext_c;
      B_SEL_ZEXT: b_c = imm_zext_c;
      default:    b_c = id_rt_data;
    endcase
  end

  // Next EX contents: flush beats stall, stall holds, id_valid=0 inserts a bubble
  always_comb begin
    ctrl_d = ctrl_q;
    a_d    = a_q;
    b_d    = b_q;
    sd_d   = sd_q;
    if (flush) begin
      ctrl_d = '0;
      a_d    = '0;
      b_d    = '0;
      sd_d   = '0;
    end else if (!stall) begin
      if (id_valid) begin
        ctrl_d.valid       = 1'b1;
        ctrl_d.alu_control = dec_c.alu_control;
        ctrl_d.reg_write   = dec_c.reg_write;
        ctrl_d.mem_read    = dec_c.mem_read;
        ctrl_d.mem_write   = dec_c.mem_write;
        ctrl_d.branch      = dec_c.branch;
        ctrl_d.illegal     = dec_c.illegal;
        a_d                = id_rs_data;
        b_d                = b_c;
        sd_d               = dec_c.store_rt ? id_rt_data : '0;
      end else begin
        ctrl_d = '0;
        a_d    = '0;
        b_d    = '0;
        sd_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sd_q   <= sd_d;
    end
  end

  assign ex_valid       = ctrl_q.valid;
  assign ex_alu_control = ctrl_q.alu_control;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_illegal     = ctrl_q.illegal;
  assign ex_a           = a_q;
  assign ex_b           = b_q;
  assign ex_store_data  = sd_q;

endmodule

// File: tb/tb_kim_alu_dec_idex_p.sv
// Directed + randomized bench for kim_alu_dec_idex_p against an instruction-level
// reference model of the EX register.
module tb_kim_alu_dec_idex_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit        valid;
    bit [3:0]  alu;
    bit        rw, mr, mw, br, ill;
    bit [31:0] a, b, sd;
    bit        chk_data;
    bit        chk_sd;
  } exp_t;

  exp_t exp_q;

  kim_alu_dec_idex_p #(.ALU_DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_funct       (id_funct),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_a           (ex_a),
    .ex_b           (ex_b),
    .ex_store_data  (ex_store_data),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_illegal     (ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid:0, alu:4'h0, rw:0, mr:0, mw:0, br:0, ill:0,
          a:32'h0, b:32'h0, sd:32'h0, chk_data:1, chk_sd:1};
    return e;
  endfunction

  // Instruction semantics: what the EX stage must carry for one valid instruction
  function automatic exp_t decode(input bit [5:0] op, input bit [5:0] fn,
                                  input bit [31:0] rs, input bit [31:0] rt,
                                  input bit [15:0] imm);
    exp_t e;
    bit [31:0] sx, zx;
    zx = {16'h0, imm};
    sx = imm[15] ? (32'hFFFF_0000 | zx) : zx;
    e = bubble();
    e.valid = 1; e.alu = 4'd2; e.a = rs; e.b = rt; e.chk_sd = 0;
    case (op)
      6'h00: begin
        e.rw = 1;
        case (fn)
          6'h20: e.alu = 4'd2;
          6'h22: e.alu = 4'd6;
          6'h24: e.alu = 4'd0;
          6'h25: e.alu = 4'd1;
          6'h27: e.alu = 4'd12;
          6'h2A: e.alu = 4'd7;
          default: begin e.rw = 0; e.ill = 1; end
        endcase
      end
      6'h23: begin e.b = sx; e.mr = 1; e.rw = 1; end
      6'h2B: begin e.b = sx; e.mw = 1; e.sd = rt; e.chk_sd = 1; end
      6'h04: begin e.alu = 4'd6; e.br = 1; end
      6'h08: begin e.b = sx; e.rw = 1; end
      6'h0A: begin e.alu = 4'd7; e.b = sx; e.rw = 1; end
      6'h0C: begin e.alu = 4'd0; e.b = zx; e.rw = 1; end
      6'h0D: begin e.alu = 4'd1; e.b = zx; e.rw = 1; end
      default: e.ill = 1;
    endcase
    if (e.ill) e.chk_data = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid),       32'(exp_q.valid));
    chk({tag, ".alu"},   32'(ex_alu_control), 32'(exp_q.alu));
    chk({tag, ".rw"},    32'(ex_reg_write),   32'(exp_q.rw));
    chk({tag, ".mr"},    32'(ex_mem_read),    32'(exp_q.mr));
    chk({tag, ".mw"},    32'(ex_mem_write),   32'(exp_q.mw));
    chk({tag, ".br"},    32'(ex_branch),      32'(exp_q.br));
    chk({tag, ".ill"},   32'(ex_illegal),     32'(exp_q.ill));
    if (exp_q.chk_data) begin
      chk({tag, ".a"}, ex_a, exp_q.a);
      chk({tag, ".b"}, ex_b, exp_q.b);
    end
    if (exp_q.chk_sd) chk({tag, ".sd"}, ex_store_data, exp_q.sd);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n || flush) exp_q = bubble();
    else if (!stall) begin
      if (id_valid) exp_q = decode(id_op, id_funct, id_rs_data, id_rt_data, id_imm);
      else exp_q = bubble();
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit [5:0] op, input bit [5:0] fn,
                       input bit [31:0] rs, input bit [31:0] rt, input bit [15:0] imm);
    id_valid = v; id_op = op; id_funct = fn;
    id_rs_data = rs; id_rt_data = rt; id_imm = imm;
  endtask

  initial begin
    bit [5:0] ops [11];
    bit [5:0] fns [7];
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h11};
    exp_q = bubble();
    rst_n = 0; stall = 0; flush = 0;
    drive(1, 6'h00, 6'h20, 32'h11, 32'h22, 16'h1234);

    // Reset, even with a valid instruction presented
    tick("reset");
    tick("reset2");

    // R-type sub
    rst_n = 1;
    drive(1, 6'h00, 6'h22, 32'd7, 32'd3, 16'h0);
    tick("rsub");
    chk("rsub.alu_lit", 32'(ex_alu_control), 32'h6);
    chk("rsub.b_lit", ex_b, 32'd3);

    // lw with negative offset
    drive(1, 6'h23, 6'h00, 32'h100, 32'h55, 16'hFFFC);
    tick("lw");
    chk("lw.b_lit", ex_b, 32'hFFFF_FFFC);
    chk("lw.mr_lit", 32'(ex_mem_read), 32'h1);

    // ori with bit 15 set zero-extends
    drive(1, 6'h0D, 6'h00, 32'h0F0F, 32'h0, 16'h8000);
    tick("ori");
    chk("ori.b_lit", ex_b, 32'h0000_8000);
    chk("ori.alu_lit", 32'(ex_alu_control), 32'h1);

    // Stall 3 cycles while ID changes
    drive(1, 6'h08, 6'h00, 32'h40, 32'h0, 16'h8001);
    tick("addi");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 6'h00, 6'h24, $urandom, $urandom, 16'($urandom));
      tick("stall");
      chk("stall.b_lit", ex_b, 32'hFFFF_8001);
    end
    stall = 0;
    drive(1, 6'h0C, 6'h00, 32'h77, 32'h0, 16'hFFFF);
    tick("post_stall");
    chk("andi.b_lit", ex_b, 32'h0000_FFFF);

    // Flush beats stall
    drive(1, 6'h04, 6'h00, 32'h5, 32'h5, 16'h0010);
    tick("beq");
    stall = 1; flush = 1;
    tick("flush_stall");
    chk("flush.valid_lit", 32'(ex_valid), 32'h0);
    stall = 0; flush = 0;

    // Illegal opcode
    drive(1, 6'h3F, 6'h00, 32'h1, 32'h2, 16'h3);
    tick("illegal");
    chk("illegal.ill_lit", 32'(ex_illegal), 32'h1);

    // Bubble on id_valid=0
    drive(0, 6'h23, 6'h00, 32'h9, 32'h9, 16'h9);
    tick("bubble");

    // Reset during a stall holding a sw
    drive(1, 6'h2B, 6'h00, 32'h200, 32'hCAFE_F00D, 16'h0004);
    tick("sw");
    chk("sw.sd_lit", ex_store_data, 32'hCAFE_F00D);
    stall = 1;
    tick("sw_hold");
    rst_n = 0;
    tick("rst_in_stall");
    chk("rst_in_stall.sd_lit", ex_store_data, 32'h0);
    rst_n = 1; stall = 0;
    drive(1, 6'h00, 6'h2A, 32'hA, 32'hB, 16'h0);
    tick("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit [5:0] op, fn;
      op = ops[$urandom_range(0, 10)];
      if (op == 6'h3F) op = 6'($urandom);
      fn = fns[$urandom_range(0, 6)];
      drive($urandom_range(0, 99) < 85, op, fn, $urandom, $urandom, 16'($urandom));
      stall = $urandom_range(0, 99) < 20;
      flush = $urandom_range(0, 99) < 10;
      rst_n = !($urandom_range(0, 99) < 3);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kim_alu_dec_idex_p.md
KIM_ALU_DEC_IDEX_P -- requirements
Module: kim_alu_dec_idex_p

Interface
REQ-001 SHALL have parameter ALU_DATA_WIDTH, default 32, datapath width of operand and immediate outputs.
REQ-002 SHALL use a single clock and a synchronous, active-low reset; ports named as below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_op  input  6  MIPS opcode field.
REQ-007 id_funct  input  6  MIPS funct field (R-type only).
REQ-008 id_rs_data  input  ALU_DATA_WIDTH  rs register value.
REQ-009 id_rt_data  input  ALU_DATA_WIDTH  rt register value.
REQ-010 id_imm  input  16  immediate field.
REQ-011 stall  input  1  hold EX register contents.
REQ-012 flush  input  1  replace EX contents with bubble.
REQ-013 ex_valid  output  1  EX register holds a real instruction.
REQ-014 ex_alu_control  output  4  ALU operation code for EX stage.
REQ-015 ex_a  output  ALU_DATA_WIDTH  ALU operand A (rs).
REQ-016 ex_b  output  ALU_DATA_WIDTH  ALU operand B (rt or extended immediate).
REQ-017 ex_store_data  output  ALU_DATA_WIDTH  rt value for sw.
REQ-018 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal  output  1 each  EX control flags.

Function
REQ-019 ALU codes SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-020 R-type (op 0x00) SHALL decode funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; b = rt; reg_write = 1.
REQ-021 lw 0x23: ADD, b = sign-ext imm, mem_read = 1, reg_write = 1; sw 0x2B: ADD, b = sign-ext imm, mem_write = 1, store_data = rt.
REQ-022 beq 0x04: SUB, b = rt, branch = 1; addi 0x08: ADD sign-ext; slti 0x0A: SLT sign-ext; andi 0x0C: AND zero-ext; ori 0x0D: OR zero-ext; I-type ALU ops set reg_write = 1.
REQ-023 Any other op/funct with id_valid = 1 SHALL latch ex_illegal = 1, ex_valid = 1, alu_control ADD, all other control flags 0.
REQ-024 Latency SHALL be exactly one cycle: ID inputs sampled at edge N appear on ex_* after edge N.
REQ-025 id_valid = 0 SHALL load a bubble: ex_valid = 0, all flags 0, alu_control 0000, data outputs 0.
REQ-026 stall = 1 SHALL hold every ex_* output unchanged.
REQ-027 flush = 1 SHALL load a bubble regardless of stall or id_valid (flush priority over stall).
REQ-028 Control flags SHALL be 0 whenever ex_valid = 0 (no write/mem side effect from bubbles).
REQ-029 Sign extension SHALL replicate id_imm[15] to ALU_DATA_WIDTH; zero extension pads 0.

Reset
REQ-030 rst_n = 0 at a clock edge SHALL force all outputs to bubble values (all zero), overriding stall and flush.
REQ-031 Reset asserted mid-stall SHALL discard held instruction; first post-reset edge loads new ID inputs normally.

Structure
REQ-032 ALU control codes, opcodes and funct codes SHALL live in shared package kim_alu_pkg, used also by the ALU.
REQ-033 Combinational decode SHALL be sub-module kim_alu_dec_p (op, funct -> alu_control, flags, imm-select, illegal); top holds extension, muxing and EX register.

Verification
REQ-034 R-type sub: op 0x00, funct 0x22, rs 7, rt 3, valid -> next cycle ex_alu_control 0110, ex_a 7, ex_b 3, reg_write 1, valid 1.
REQ-035 lw with imm 0xFFFC, rs 0x100 -> ex_alu_control 0010, ex_b 0xFFFFFFFC, mem_read 1, reg_write 1; ori imm 0x8000 -> ex_b 0x00008000, alu_control 0001.
REQ-036 Stall 3 cycles while ID inputs change -> ex_* constant for 3 cycles, then new instruction one cycle after stall drops.
REQ-037 flush and stall both 1 with valid beq -> ex_valid 0, all flags 0 next cycle.
REQ-038 op 0x3F, valid -> ex_illegal 1, ex_valid 1, reg_write 0, mem_write 0.
REQ-039 rst_n low for one edge during stall with valid sw held -> all outputs 0; next edge loads current ID inputs.
